multi_glitch_filter: RTL and testbench
======================================

# multi_glitch_filter

Parametrised, multi-channel deglitcher for slow external lines such as controller data and console bus strobes. Each channel synchronises its asynchronous input, then forwards a level change only after the input has held the new level for a programmable run of consecutive samples. Rise and fall thresholds are independent. The block emits one-cycle edge pulses and keeps a saturating count of rejected glitches across all channels for debug readout.

## Interface
- CHANNELS, 4, number of independent lines filtered
- SYNC_STAGES, 2, flip-flops in each input synchroniser (≥1)
- RISE_CYCLES, 6, consecutive high samples required to move line_out 0→1 (≥1)
- FALL_CYCLES, 6, consecutive low samples required to move line_out 1→0 (≥1)
- INIT_LEVEL, 1, reset level of line_out and of every synchroniser flop
- CNT_W, 16, width of glitch_count

- sys_clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- line_in  in  CHANNELS  raw asynchronous input lines
- clear_count  in  1  synchronous clear of glitch_count
- line_out  out  CHANNELS  filtered levels; reset to INIT_LEVEL on every bit
- rise_pulse  out  CHANNELS  one-cycle high when the corresponding line_out goes 0→1; reset 0
- fall_pulse  out  CHANNELS  one-cycle high when the corresponding line_out goes 1→0; reset 0
- glitch_count  out  CNT_W  saturating total of rejected glitches; reset 0

## Operation
- Per channel i, a SYNC_STAGES-deep shift register produces the synchronised sample s[i].
- Each channel has a run counter cnt[i]. Its width is clog2(max(RISE_CYCLES, FALL_CYCLES)+1).
- Threshold per channel: T = RISE_CYCLES when line_out[i]=0, and T = FALL_CYCLES when line_out[i]=1.
- Each edge, per channel:
  - s[i] == line_out[i] and cnt[i] == 0: hold.
  - s[i] == line_out[i] and cnt[i] != 0: cnt[i] ← 0. This counts as one rejected glitch on channel i this cycle.
  - s[i] != line_out[i] and cnt[i] == T-1: toggle line_out[i], set cnt[i] ← 0, and assert rise_pulse[i] or fall_pulse[i] for the next cycle.
  - s[i] != line_out[i] otherwise: cnt[i] ← cnt[i]+1.
- Edge pulses are registered. Each is high exactly one cycle, coincident with the first cycle of the new line_out level.
- glitch_count update each edge:
  - clear_count=1: glitch_count ← 0. Clear wins over any simultaneous reject.
  - Otherwise: glitch_count ← min(glitch_count + R, 2^CNT_W − 1), where R is the number of channels rejecting this cycle (0..CHANNELS).
  - Compute the sum at CNT_W+clog2(CHANNELS+1) bits before saturating. glitch_count never wraps.
- Channels are fully independent. Any combination of channels may toggle or reject on the same edge.
- Asserting reset mid-run discards all pending counts:
  - line_out and the synchronisers return to INIT_LEVEL.
  - Pulses and glitch_count return to 0.
  - No pulse is emitted for the reset-induced level change.

## Timing
- Latency: line_out[i] changes on the (SYNC_STAGES+T)-th rising edge after line_in[i] changes. The first edge that captures the new value counts as edge 1.
- Defaults: 8 edges for both rising and falling transitions.
- A glitch is rejected when its synchronised width is shorter than T samples.
- The reject is counted on the edge that first sees s[i] back at the line_out level.
- A run of exactly T samples passes. A run of T-1 samples is rejected.
- Asymmetric thresholds take effect immediately. After a toggle, the next run is measured against the opposite threshold.
- Release of reset is synchronised by the system. The first filter evaluation occurs on the first edge after deassertion.
- There is no handshake. Outputs are valid every cycle.

## Test plan
- **Reset levels:** hold reset with INIT_LEVEL=1, then release with all line_in=1 → line_out=all 1, no pulses, glitch_count=0 for 50 cycles.
- **Threshold boundary, defaults:**
  - Drive ch0 low for 5 cycles, then high → line_out[0] stays 1 and glitch_count=1.
  - Drive ch0 low for 6 cycles → line_out[0] falls on edge 8 and fall_pulse[0] is high exactly one cycle.
- **Asymmetric thresholds:** set RISE_CYCLES=3, FALL_CYCLES=10.
  - 3-cycle high on ch1 from 0 → passes, rise at edge 5.
  - Following 9-cycle low → rejected, glitch_count increments by 1.
- **Simultaneous rejects:** 2-cycle low pulses on all 4 channels on the same edge → glitch_count increments by 4 in a single cycle. Other channels concurrently toggling are unaffected.
- **Saturation and clear:**
  - Set CNT_W=4 and inject 20 glitches → glitch_count=15 and does not wrap.
  - Assert clear_count on the same edge as a new reject → glitch_count=0.
- **Reset mid-operation:** assert reset while cnt[0]=4 on a pending fall → line_out[0]=1 immediately, no fall_pulse. After release, ch0 needs a full new 6-sample run to fall.

Source files
------------

// File: rtl/multi_glitch_filter_if.sv
// Bundle of filter lines and debug counter between a line source and the
// multi_glitch_filter block.
//
// Handshake: none. line_in and clear_count are sampled on every rising
// clock edge, and line_out, rise_pulse, fall_pulse and glitch_count are
// valid every cycle. There is no valid/ready pair because nothing is ever
// stalled or dropped.
interface multi_glitch_filter_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0] line_in;
  logic                clear_count;
  logic [CHANNELS-1:0] line_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CNT_W-1:0]    glitch_count;

  // Source side: drives the raw lines and the counter clear.
  modport master (
    output line_in, clear_count,
    input  line_out, rise_pulse, fall_pulse, glitch_count
  );

  // Filter side: consumes the raw lines, produces the filtered view.
  modport slave (
    input  line_in, clear_count,
    output line_out, rise_pulse, fall_pulse, glitch_count
  );
endinterface

// File: rtl/multi_glitch_filter.sv
// Multi-channel deglitcher. Each channel synchronises its raw line, then
// only forwards a level change once the new level has been seen for a run
// of RISE_CYCLES (0->1) or FALL_CYCLES (1->0) consecutive samples. Runs
// that end early are counted as rejected glitches in a shared saturating
// counter.
module multi_glitch_filter #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RISE_CYCLES = 6,
  parameter int FALL_CYCLES = 6,
  parameter int INIT_LEVEL  = 1,
  parameter int CNT_W       = 16
) (
  input logic                  sys_clk,
  input logic                  reset,
  multi_glitch_filter_if.slave bus
);

  localparam int MAX_T = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int RW    = $clog2(CHANNELS + 1);
  localparam int SUM_W = CNT_W + RW;

  localparam logic             INIT_BIT  = (INIT_LEVEL != 0);
  localparam logic [CW-1:0]    RISE_LAST = CW'(RISE_CYCLES - 1);
  localparam logic [CW-1:0]    FALL_LAST = CW'(FALL_CYCLES - 1);
  localparam logic [SUM_W-1:0] SAT       = {{RW{1'b0}}, {CNT_W{1'b1}}};

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] samp;

  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] line_q, line_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] rej;

  logic [RW-1:0]       rej_cnt;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    count_q, count_d;

  assign samp = sync_q[SYNC_STAGES-1];

  // Input synchronisers: reset to the idle level so a quiet line does not
  // look like a pending transition right after reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {CHANNELS{INIT_BIT}};
    end else begin
      sync_q[0] <= bus.line_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-channel run counter: the threshold follows the current output
  // level, so a freshly toggled channel is judged against the opposite
  // threshold on the very next sample.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      line_d[i] = line_q[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      rej[i]    = 1'b0;
      if (samp[i] == line_q[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = '0;
          rej[i]   = 1'b1;
        end
      end else if (cnt_q[i] == (line_q[i] ? FALL_LAST : RISE_LAST)) begin
        line_d[i] = ~line_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = ~line_q[i];
        fall_d[i] = line_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Glitch counter: add this cycle's rejects at a width that cannot
  // overflow, then clamp, so the count sticks at all-ones instead of
  // wrapping. A clear beats any simultaneous reject.
  always_comb begin
    rej_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) rej_cnt = rej_cnt + RW'(rej[i]);
    sum = {{RW{1'b0}}, count_q} + SUM_W'(rej_cnt);
    if (bus.clear_count)  count_d = '0;
    else if (sum > SAT)   count_d = {CNT_W{1'b1}};
    else                  count_d = sum[CNT_W-1:0];
  end

  // Filter state, pulses and counter; reset drops any run in progress and
  // never produces a pulse for the forced level change.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      line_q  <= {CHANNELS{INIT_BIT}};
      rise_q  <= '0;
      fall_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      line_q  <= line_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.line_out     = line_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.glitch_count = count_q;

endmodule

// File: tb/tb_multi_glitch_filter.sv
// Directed bench for multi_glitch_filter. Three instances cover the default
// configuration, asymmetric thresholds with a low idle level, and a narrow
// saturating counter. Inputs change and outputs are sampled on the falling
// clock edge; "edge k" below is the k-th rising edge after an input change.
module tb_multi_glitch_filter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  multi_glitch_filter_if #(.CHANNELS(4), .CNT_W(16)) ia ();
  multi_glitch_filter_if #(.CHANNELS(4), .CNT_W(16)) ib ();
  multi_glitch_filter_if #(.CHANNELS(4), .CNT_W(4))  ic ();

  multi_glitch_filter #(
    .CHANNELS(4), .SYNC_STAGES(2), .RISE_CYCLES(6), .FALL_CYCLES(6),
    .INIT_LEVEL(1), .CNT_W(16)
  ) dut_a (.sys_clk(clk), .reset(rst), .bus(ia));

  multi_glitch_filter #(
    .CHANNELS(4), .SYNC_STAGES(2), .RISE_CYCLES(3), .FALL_CYCLES(10),
    .INIT_LEVEL(0), .CNT_W(16)
  ) dut_b (.sys_clk(clk), .reset(rst), .bus(ib));

  multi_glitch_filter #(
    .CHANNELS(4), .SYNC_STAGES(2), .RISE_CYCLES(6), .FALL_CYCLES(6),
    .INIT_LEVEL(1), .CNT_W(4)
  ) dut_c (.sys_clk(clk), .reset(rst), .bus(ic));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    ia.line_in     = 4'hF;
    ia.clear_count = 1'b0;
    ib.line_in     = 4'h0;
    ib.clear_count = 1'b0;
    ic.line_in     = 4'hF;
    ic.clear_count = 1'b0;

    // Reset levels
    tick(3);
    check_eq("rst_a_line", 32'(ia.line_out), 32'hF);
    check_eq("rst_b_line", 32'(ib.line_out), 32'h0);
    check_eq("rst_a_pulses", 32'({ia.rise_pulse, ia.fall_pulse}), 32'h0);
    check_eq("rst_a_count", 32'(ia.glitch_count), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      check_eq("idle_a_line", 32'(ia.line_out), 32'hF);
      check_eq("idle_a_pulses", 32'({ia.rise_pulse, ia.fall_pulse}), 32'h0);
      check_eq("idle_a_count", 32'(ia.glitch_count), 32'h0);
    end

    // 5-sample low on ch0: rejected on edge 8
    ia.line_in[0] = 1'b0;
    tick(5);
    ia.line_in[0] = 1'b1;
    tick(2);
    check_eq("g5_count_e7", 32'(ia.glitch_count), 32'h0);
    tick(1);
    check_eq("g5_count_e8", 32'(ia.glitch_count), 32'h1);
    check_eq("g5_line_e8", 32'(ia.line_out), 32'hF);
    tick(3);
    check_eq("g5_line_late", 32'(ia.line_out), 32'hF);
    check_eq("g5_fall_late", 32'(ia.fall_pulse), 32'h0);

    // 6-sample low on ch0: falls on edge 8, then rises 6 samples later
    ia.line_in[0] = 1'b0;
    tick(6);
    ia.line_in[0] = 1'b1;
    tick(1);
    check_eq("p6_line_e7", 32'(ia.line_out), 32'hF);
    check_eq("p6_fall_e7", 32'(ia.fall_pulse), 32'h0);
    tick(1);
    check_eq("p6_line_e8", 32'(ia.line_out), 32'hE);
    check_eq("p6_fall_e8", 32'(ia.fall_pulse), 32'h1);
    tick(1);
    check_eq("p6_fall_e9", 32'(ia.fall_pulse), 32'h0);
    check_eq("p6_line_e9", 32'(ia.line_out), 32'hE);
    tick(4);
    check_eq("p6_line_e13", 32'(ia.line_out), 32'hE);
    tick(1);
    check_eq("p6_line_e14", 32'(ia.line_out), 32'hF);
    check_eq("p6_rise_e14", 32'(ia.rise_pulse), 32'h1);
    tick(1);
    check_eq("p6_rise_e15", 32'(ia.rise_pulse), 32'h0);
    check_eq("p6_count", 32'(ia.glitch_count), 32'h1);

    // 2-sample low on all channels: four rejects on one edge
    tick(2);
    ia.line_in = 4'h0;
    tick(2);
    ia.line_in = 4'hF;
    tick(2);
    check_eq("sim4_count_e4", 32'(ia.glitch_count), 32'h1);
    tick(1);
    check_eq("sim4_count_e5", 32'(ia.glitch_count), 32'h5);
    check_eq("sim4_line", 32'(ia.line_out), 32'hF);

    // ch0..2 glitch while ch3 holds low long enough to fall
    tick(3);
    ia.line_in = 4'h0;
    tick(2);
    ia.line_in = 4'h7;
    tick(2);
    check_eq("mix_count_e4", 32'(ia.glitch_count), 32'h5);
    tick(1);
    check_eq("mix_count_e5", 32'(ia.glitch_count), 32'h8);
    tick(2);
    check_eq("mix_line_e7", 32'(ia.line_out), 32'hF);
    tick(1);
    check_eq("mix_line_e8", 32'(ia.line_out), 32'h7);
    check_eq("mix_fall_e8", 32'(ia.fall_pulse), 32'h8);
    ia.line_in = 4'hF;
    tick(10);
    check_eq("mix_line_back", 32'(ia.line_out), 32'hF);
    check_eq("mix_count_back", 32'(ia.glitch_count), 32'h8);

    // Asymmetric thresholds: 3 high passes (edge 5), following 9 low rejected
    ib.line_in[1] = 1'b1;
    tick(3);
    ib.line_in[1] = 1'b0;
    tick(1);
    check_eq("asym_line_e4", 32'(ib.line_out), 32'h0);
    tick(1);
    check_eq("asym_line_e5", 32'(ib.line_out), 32'h2);
    check_eq("asym_rise_e5", 32'(ib.rise_pulse), 32'h2);
    tick(1);
    check_eq("asym_rise_e6", 32'(ib.rise_pulse), 32'h0);
    tick(6);
    ib.line_in[1] = 1'b1;
    tick(2);
    check_eq("asym_count_e14", 32'(ib.glitch_count), 32'h0);
    check_eq("asym_line_e14", 32'(ib.line_out), 32'h2);
    tick(1);
    check_eq("asym_count_e15", 32'(ib.glitch_count), 32'h1);
    check_eq("asym_line_e15", 32'(ib.line_out), 32'h2);
    check_eq("asym_fall_e15", 32'(ib.fall_pulse), 32'h0);

    // Saturation at 4 bits: 20 glitches leave the count at 15
    for (int g = 0; g < 20; g++) begin
      ic.line_in[0] = 1'b0;
      tick(2);
      ic.line_in[0] = 1'b1;
      tick(4);
      if (g == 9) check_eq("sat_count_10", 32'(ic.glitch_count), 32'd10);
    end
    check_eq("sat_count_20", 32'(ic.glitch_count), 32'd15);
    check_eq("sat_line", 32'(ic.line_out), 32'hF);

    // Clear on the same edge as a reject: clear wins
    ic.line_in[0] = 1'b0;
    tick(2);
    ic.line_in[0] = 1'b1;
    tick(2);
    ic.clear_count = 1'b1;
    tick(1);
    ic.clear_count = 1'b0;
    check_eq("clr_count_e5", 32'(ic.glitch_count), 32'h0);
    tick(1);
    check_eq("clr_count_e6", 32'(ic.glitch_count), 32'h0);
    ic.line_in[0] = 1'b0;
    tick(2);
    ic.line_in[0] = 1'b1;
    tick(4);
    check_eq("clr_count_resume", 32'(ic.glitch_count), 32'h1);

    // Reset with a fall pending on ch0 (run count 4)
    ia.line_in[0] = 1'b0;
    tick(6);
    check_eq("mrst_line_pre", 32'(ia.line_out), 32'hF);
    rst = 1'b1;
    #1;
    check_eq("mrst_line_now", 32'(ia.line_out), 32'hF);
    check_eq("mrst_fall_now", 32'(ia.fall_pulse), 32'h0);
    check_eq("mrst_count_now", 32'(ia.glitch_count), 32'h0);
    tick(2);
    check_eq("mrst_line_hold", 32'(ia.line_out), 32'hF);
    rst = 1'b0;
    tick(7);
    check_eq("mrst_line_e7", 32'(ia.line_out), 32'hF);
    check_eq("mrst_fall_e7", 32'(ia.fall_pulse), 32'h0);
    tick(1);
    check_eq("mrst_line_e8", 32'(ia.line_out), 32'hE);
    check_eq("mrst_fall_e8", 32'(ia.fall_pulse), 32'h1);
    check_eq("mrst_count_e8", 32'(ia.glitch_count), 32'h0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
